ps2_line_buffer: RTL

- System-clock consumer directly downstream of the PS/2 keyboard decoder. Takes its ASCII byte and valid strobe, which are generated on the PS/2 clock.
- Brings the strobe into the system domain and performs line editing: append, backspace, Enter.
- On Enter, streams the committed line to a downstream consumer (UART/LCD writer) over a valid/ready interface, terminated by 0x0D.

---
 rtl/ps2_line_buffer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ps2_line_buffer.sv
// Line-editing buffer fed by the PS/2 keyboard decoder; streams the committed line plus 0x0D on Enter.
// Optional echo port set enabled by defining PS2_LINE_BUFFER_ECHO_EN.
module ps2_line_buffer #(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [7:0]    ascii_in,
   input  logic          ascii_valid_in,
   output logic [7:0]    out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW:0]   line_len,
   output logic          overflow,
   output logic          dropped
`ifdef PS2_LINE_BUFFER_ECHO_EN
   ,
   output logic [7:0]    echo_data,
   output logic          echo_valid
`endif
);

   // state | meaning
   // EDIT  | keyboard events edit the line buffer
   // DRAIN | committed line streaming out, keyboard events discarded
   typedef enum logic {EDIT, DRAIN} state_t;

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   state_t      state_q, state_d;
   logic [2:0]  sync_q;
   logic [AW:0] len_q, len_d;
   logic [AW:0] idx_q, idx_d;
   logic        out_valid_q, out_valid_d;
   logic        ovf_q, ovf_d;
   logic        dropped_q, dropped_d;
   logic        wr_en;
   logic [7:0]  wr_data;
   logic [7:0]  mem_q [DEPTH];
   logic        evt;
   logic [7:0]  key_ch;
   logic        is_print;
`ifdef PS2_LINE_BUFFER_ECHO_EN
   logic        echo_valid_q, echo_valid_d;
   logic [7:0]  echo_data_q, echo_data_d;
`endif

   // sync_q[1:0] is the synchronizer, sync_q[2] the edge-detect history
   assign evt      = sync_q[1] & ~sync_q[2];
   assign key_ch   = (ascii_in == 8'h09) ? 8'h20 : ascii_in;
   assign is_print = (key_ch >= 8'h20) && (key_ch <= 8'h7E);

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      ovf_d       = ovf_q;
      dropped_d   = 1'b0;
      wr_en       = 1'b0;
      wr_data     = 8'h00;
`ifdef PS2_LINE_BUFFER_ECHO_EN
      echo_valid_d = 1'b0;
      echo_data_d  = echo_data_q;
`endif
      case (state_q)
         EDIT: begin
            if (evt) begin
               if (is_print) begin
                  if (len_q < FULL) begin
                     wr_en   = 1'b1;
                     wr_data = key_ch;
                     len_d   = len_q + 1'b1;
`ifdef PS2_LINE_BUFFER_ECHO_EN
                     echo_valid_d = 1'b1;
                     echo_data_d  = key_ch;
`endif
                  end else begin
                     ovf_d = 1'b1;
                  end
               end else if (ascii_in == 8'h08) begin
                  if (len_q != '0) begin
                     len_d = len_q - 1'b1;
`ifdef PS2_LINE_BUFFER_ECHO_EN
                     echo_valid_d = 1'b1;
                     echo_data_d  = 8'h08;
`endif
                  end
               end else if (ascii_in == 8'h0D) begin
                  state_d     = DRAIN;
                  idx_d       = '0;
                  out_valid_d = 1'b1;
`ifdef PS2_LINE_BUFFER_ECHO_EN
                  echo_valid_d = 1'b1;
                  echo_data_d  = 8'h0D;
`endif
               end
            end
         end
         DRAIN: begin
            dropped_d = evt;
            if (out_valid_q && out_ready) begin
               if (idx_q == len_q) begin
                  state_d     = EDIT;
                  out_valid_d = 1'b0;
                  len_d       = '0;
                  ovf_d       = 1'b0;
                  idx_d       = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = EDIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= EDIT;
         sync_q      <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         dropped_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= {sync_q[1:0], ascii_valid_in};
         len_q       <= len_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
         dropped_q   <= dropped_d;
      end
   end

   // Storage needs no reset: line_len gates every read.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[len_q[AW-1:0]] <= wr_data;
   end

`ifdef PS2_LINE_BUFFER_ECHO_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         echo_valid_q <= 1'b0;
         echo_data_q  <= 8'h00;
      end else begin
         echo_valid_q <= echo_valid_d;
         echo_data_q  <= echo_data_d;
      end
   end
   assign echo_valid = echo_valid_q;
   assign echo_data  = echo_data_q;
`endif

   assign out_data  = !out_valid_q ? 8'h00 :
                      (idx_q < len_q) ? mem_q[idx_q[AW-1:0]] : 8'h0D;
   assign out_valid = out_valid_q;
   assign line_len  = len_q;
   assign overflow  = ovf_q;
   assign dropped   = dropped_q;

endmodule
